// File: rtl/vga_pkg.sv
// Shared VGA raster constants, colour width and scheduler FSM encoding.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 800;
  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned RGB_W        = 12;

  localparam logic [2:0] BG_IDX = 3'd7;

  localparam logic [1:0] WAIT_VB = 2'd0;
  localparam logic [1:0] STEP    = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

endpackage

// File: rtl/sprite_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins; valid is low when no bit is set.
module sprite_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         valid
);

  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    // Scan high to low so the last hit recorded is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Frame step scheduler and fixed-priority sprite compositor for the VGA raster.
// Optional per-frame collision latch is built when SPRITE_COLLIDE_EN is defined.
module sprite_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned NUM_SPR  = 4,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              X,
  input  logic [10:0]              Y,
  input  logic [NUM_SPR-1:0]       sprYes,
  input  logic [RGB_W*NUM_SPR-1:0] sprRGB,
  input  logic [RGB_W-1:0]         bgRGB,
  input  logic                     pause,
  input  logic                     stepOnce,
  output logic                     step,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic [2:0]               hitIdx,
  output logic [NUM_SPR-1:0]       collide,
  output logic [3:0]               frameCnt
);

  logic             active, vb_entry;
  logic [2:0]       win_idx;
  logic             win_valid;
  logic [RGB_W-1:0] win_rgb, rgb_d, rgb_q;
  logic [2:0]       hit_d, hit_q;
  logic [1:0]       state_d, state_q;
  logic [3:0]       cnt_d, cnt_q;
  logic             latch_d, latch_q, so_prev_q;

  assign active   = (X < 11'(H_ACTIVE)) && (Y < 11'(V_ACTIVE));
  assign vb_entry = (X == 11'd0) && (Y == 11'(V_ACTIVE));

  sprite_prio_enc #(
    .N (NUM_SPR)
  ) u_enc (
    .req   (sprYes),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    win_rgb = bgRGB;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (win_idx == 3'(i)) win_rgb = sprRGB[RGB_W*i +: RGB_W];
    end
  end

  always_comb begin
    rgb_d = '0;
    hit_d = BG_IDX;
    if (active) begin
      if (win_valid) begin
        rgb_d = win_rgb;
        hit_d = win_idx;
      end else begin
        rgb_d = bgRGB;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    if (!pause) begin
      latch_d = 1'b0;
    end else if (stepOnce && !so_prev_q) begin
      latch_d = 1'b1;
    end
    case (state_q)
      WAIT_VB: begin
        if (vb_entry) begin
          // While paused the frame counter freezes; only a latched single-step fires.
          if (pause) begin
            if (latch_q) begin
              state_d = STEP;
              latch_d = 1'b0;
            end
          end else if ({1'b0, cnt_q} + 5'd1 == 5'(STEP_DIV)) begin
            state_d = STEP;
            cnt_d   = 4'd0;
          end else if (cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      STEP:    state_d = HOLD;
      HOLD:    if (Y < 11'(V_ACTIVE)) state_d = WAIT_VB;
      default: state_d = WAIT_VB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT_VB;
      cnt_q     <= 4'd0;
      latch_q   <= 1'b0;
      so_prev_q <= 1'b0;
      rgb_q     <= '0;
      hit_q     <= BG_IDX;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      so_prev_q <= stepOnce;
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
    end
  end

  assign step              = (state_q == STEP);
  assign {red, green, blue} = rgb_q;
  assign hitIdx            = hit_q;
  assign frameCnt          = cnt_q;

`ifdef SPRITE_COLLIDE_EN
  logic [NUM_SPR-1:0] col_q;
  logic               multi;

  assign multi = |(sprYes & (sprYes - NUM_SPR'(1)));

  // Clearing on the step cycle takes priority and drops that cycle's hits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
    end else if (step) begin
      col_q <= '0;
    end else if (active && multi) begin
      col_q <= col_q | sprYes;
    end
  end

  assign collide = col_q;
`else
  assign collide = '0;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler with a compressed raster driven directly on X/Y.
module tb_sprite_scheduler;

`ifdef SPRITE_COLLIDE_EN
  localparam bit COL_EN = 1'b1;
`else
  localparam bit COL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] X, Y;
  logic [3:0]  sprYes;
  logic [47:0] sprRGB;
  logic [11:0] bgRGB;
  logic        pause, stepOnce;
  logic        step;
  logic [3:0]  red, green, blue;
  logic [2:0]  hitIdx;
  logic [3:0]  collide;
  logic [3:0]  frameCnt;

  int n_tests = 0;
  int n_fail  = 0;
  int step_cnt = 0;
  logic [14:0] exp_q[$];

  sprite_scheduler #(
    .NUM_SPR  (4),
    .H_ACTIVE (800),
    .V_ACTIVE (600),
    .STEP_DIV (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .X        (X),
    .Y        (Y),
    .sprYes   (sprYes),
    .sprRGB   (sprRGB),
    .bgRGB    (bgRGB),
    .pause    (pause),
    .stepOnce (stepOnce),
    .step     (step),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .hitIdx   (hitIdx),
    .collide  (collide),
    .frameCnt (frameCnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {hitIdx, rgb}: first sprite found scanning upward from index 0.
  function automatic logic [14:0] model(input logic [10:0] x, input logic [10:0] y,
                                        input logic [3:0] yes, input logic [47:0] rgb,
                                        input logic [11:0] bg);
    logic [14:0] r;
    bit found;
    r = {3'd7, 12'h000};
    found = 1'b0;
    if (x < 11'd800 && y < 11'd600) begin
      r = {3'd7, bg};
      for (int i = 0; i < 4; i++) begin
        if (!found && yes[i]) begin
          r = {3'(i), rgb[12*i +: 12]};
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic [3:0] yes);
    logic [14:0] e;
    X = x;
    Y = y;
    sprYes = yes;
    exp_q.push_back(model(x, y, yes, sprRGB, bgRGB));
    @(negedge clk);
    if (step) step_cnt++;
    e = exp_q.pop_front();
    check_eq("pix", {17'd0, hitIdx, red, green, blue}, {17'd0, e});
  endtask

  task automatic frame(input string name, input logic [3:0] act_yes, input logic [3:0] post_yes,
                       input int pulses, input logic pause_vb, input int exp_steps,
                       input logic [3:0] exp_cnt, input logic [3:0] exp_col);
    logic pause_save;
    step_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      stepOnce = (i < 2 * pulses) && (i % 2 == 0);
      drive(11'(100 + i), 11'd100, act_yes);
    end
    stepOnce = 1'b0;
    pause_save = pause;
    if (pause_vb) pause = 1'b1;
    drive(11'd0, 11'd600, 4'b0000);
    pause = pause_save;
    drive(11'd5, 11'd100, post_yes);
    drive(11'd6, 11'd100, 4'b0000);
    drive(11'd850, 11'd300, 4'b0000);
    check_eq({name, "_steps"}, step_cnt, exp_steps);
    check_eq({name, "_cnt"}, {28'd0, frameCnt}, {28'd0, exp_cnt});
    check_eq({name, "_col"}, {28'd0, collide}, COL_EN ? {28'd0, exp_col} : 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    X        = '0;
    Y        = '0;
    sprYes   = '0;
    sprRGB   = {12'h00F, 12'h0F0, 12'hF00, 12'h123};
    bgRGB    = 12'h555;
    pause    = 1'b0;
    stepOnce = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst_pix", {17'd0, hitIdx, red, green, blue}, {17'd0, 3'd7, 12'h000});
    check_eq("rst_step", {31'd0, step}, 32'd0);
    check_eq("rst_cnt", {28'd0, frameCnt}, 32'd0);
    check_eq("rst_col", {28'd0, collide}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset mid-frame with sprites hitting
    drive(11'd100, 11'd100, 4'b0011);
    drive(11'd101, 11'd100, 4'b0011);
    #2 reset = 1'b0;
    #1;
    check_eq("amid_pix", {17'd0, hitIdx, red, green, blue}, {17'd0, 3'd7, 12'h000});
    check_eq("amid_step", {31'd0, step}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Priority and collision
    drive(11'd100, 11'd100, 4'b0110);
    check_eq("prio_hit", {29'd0, hitIdx}, 32'd1);
    check_eq("prio_col", {28'd0, collide}, COL_EN ? 32'h6 : 32'd0);

    // Outside region blanks; background fill inside
    drive(11'd850, 11'd300, 4'b0001);
    bgRGB = 12'h00A;
    drive(11'd10, 11'd300, 4'b0000);
    check_eq("bg_rgb", {20'd0, red, green, blue}, 32'h00A);

    frame("f1", 4'b0001, 4'b0000, 0, 1'b0, 0, 4'd1, 4'b0110);
    frame("f2", 4'b0001, 4'b0000, 0, 1'b0, 1, 4'd0, 4'b0000);
    frame("f3", 4'b0001, 4'b0011, 0, 1'b0, 0, 4'd1, 4'b0011);
    frame("f4", 4'b0001, 4'b0011, 0, 1'b0, 1, 4'd0, 4'b0000);
    pause = 1'b1;
    frame("f5", 4'b0001, 4'b0000, 3, 1'b0, 1, 4'd0, 4'b0000);
    frame("f6", 4'b0001, 4'b0000, 0, 1'b0, 0, 4'd0, 4'b0000);
    pause = 1'b0;
    frame("f7", 4'b0001, 4'b0000, 3, 1'b0, 0, 4'd1, 4'b0000);
    frame("f8", 4'b0001, 4'b0000, 0, 1'b1, 0, 4'd1, 4'b0000);
    frame("f9", 4'b0001, 4'b0000, 0, 1'b0, 1, 4'd0, 4'b0000);
    frame("f10", 4'b0001, 4'b0000, 0, 1'b0, 0, 4'd1, 4'b0000);

    // Reset while the step pulse is high
    drive(11'd0, 11'd600, 4'b0000);
    check_eq("pre_rst_step", {31'd0, step}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_in_step", {31'd0, step}, 32'd0);
    check_eq("rst_in_cnt", {28'd0, frameCnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(11'd10, 11'd100, 4'b0000);
    check_eq("post_rst_step", {31'd0, step}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
